vga_pixel_to_cell: RTL and testbench

Inverse of the cell-index-to-coordinate mapping. Consumes the VGA raster pixel stream (x,y in raster order) and reports which heat-map grid cell, if any, each pixel falls in, plus the flat heat-RAM read address. It uses incremental counters, not dividers. Sits between the VGA driver's next-pixel coordinates and the heat-map colour lookup.

---
 rtl/vga_cell_pkg.sv | 13 +
 rtl/vga_pixel_to_cell_tracker.sv | 41 ++++
 rtl/vga_pixel_to_cell.sv | 87 ++++++++
 tb/tb_vga_pixel_to_cell.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_cell_pkg.sv
// vga_cell_pkg: geometry defaults and index types shared by the pixel-to-cell mapper
package vga_cell_pkg;
  localparam int DEF_GRID_W   = 41;
  localparam int DEF_GRID_H   = 41;
  localparam int DEF_CELL_PX  = 8;
  localparam int DEF_X_ORIGIN = 8;
  localparam int DEF_Y_ORIGIN = 8;
  localparam int DEF_ADDR_W   = 11;
  localparam int IDX_W        = 6;
  localparam int PIX_W        = 10;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/vga_pixel_to_cell_tracker.sv
// cell_axis_tracker: incremental cell index counter for one raster axis
module cell_axis_tracker
  import vga_cell_pkg::*;
#(
  parameter int N           = DEF_GRID_W,
  parameter int CELL_PX     = DEF_CELL_PX,
  parameter bit ORIGIN_ZERO = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic restart,
  input  logic origin_hit,
  input  logic seq_ok,
  output logic active,
  output idx_t idx,
  output logic wrap
);
  localparam int SW = $clog2(CELL_PX);
  logic [SW-1:0] sub;
  always_comb wrap = step && seq_ok && active && !restart && !origin_hit && sub == SW'(CELL_PX - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      idx    <= '0;
      sub    <= '0;
    end else if (restart || origin_hit) begin
      active <= restart ? ORIGIN_ZERO : 1'b1;
      idx    <= '0;
      sub    <= '0;
    end else if (step && !seq_ok) begin
      active <= 1'b0;
    end else if (step && active) begin
      sub <= wrap ? '0 : sub + SW'(1);
      if (wrap) begin
        idx    <= idx + IDX_W'(1);
        active <= idx != IDX_W'(N - 1);
      end
    end
  end
endmodule

// File: rtl/vga_pixel_to_cell.sv
// vga_pixel_to_cell: maps the raster pixel stream to heat-map cell indices and RAM address
module vga_pixel_to_cell
  import vga_cell_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int CELL_PX  = DEF_CELL_PX,
  parameter int X_ORIGIN = DEF_X_ORIGIN,
  parameter int Y_ORIGIN = DEF_Y_ORIGIN,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  pix_t              pix_x,
  input  pix_t              pix_y,
  input  logic              pix_valid,
  output logic              out_valid,
  output logic              in_grid,
  output idx_t              cell_col,
  output idx_t              cell_row,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              seq_err
);
  pix_t last_x, last_y;
  idx_t col, row;
  logic [ADDR_W-1:0] row_base;
  logic synced, x_ok, v1, err1;
  logic col_active, row_active, col_wrap, row_wrap;
  logic line_start, frame_start, x_next, y_next;
  logic col_step, col_err, col_origin, row_step, row_err, row_origin, hit;
  always_comb begin
    line_start  = pix_valid && pix_x == '0;
    frame_start = line_start && pix_y == '0;
    x_next      = pix_x == last_x + PIX_W'(1);
    y_next      = pix_y == last_y + PIX_W'(1);
    col_step    = pix_valid && pix_x != '0;
    col_err     = col_step && !x_next;
    col_origin  = col_step && x_next && pix_x == PIX_W'(X_ORIGIN);
    row_step    = line_start && !frame_start;
    row_err     = row_step && !y_next;
    row_origin  = line_start && pix_y == PIX_W'(Y_ORIGIN);
    hit         = v1 && synced && x_ok && row_active && col_active;
  end
  cell_axis_tracker #(.N(GRID_W), .CELL_PX(CELL_PX), .ORIGIN_ZERO(X_ORIGIN == 0)) u_col (
    .clk(clk), .reset(reset), .step(col_step), .restart(line_start),
    .origin_hit(col_origin), .seq_ok(x_next), .active(col_active), .idx(col), .wrap(col_wrap)
  );
  cell_axis_tracker #(.N(GRID_H), .CELL_PX(CELL_PX), .ORIGIN_ZERO(Y_ORIGIN == 0)) u_row (
    .clk(clk), .reset(reset), .step(row_step), .restart(frame_start),
    .origin_hit(row_origin), .seq_ok(y_next), .active(row_active), .idx(row), .wrap(row_wrap)
  );
  // row_base follows the row tracker so stage 2 needs only an add, never a multiply
  always_ff @(posedge clk) begin
    if (reset) begin
      last_x    <= '0;
      last_y    <= '0;
      synced    <= 1'b0;
      x_ok      <= 1'b0;
      v1        <= 1'b0;
      err1      <= 1'b0;
      row_base  <= '0;
      out_valid <= 1'b0;
      in_grid   <= 1'b0;
      cell_col  <= '0;
      cell_row  <= '0;
      cell_addr <= '0;
      seq_err   <= 1'b0;
    end else begin
      v1   <= pix_valid;
      err1 <= synced && (row_err || col_err);
      if (pix_valid) begin
        last_x <= pix_x;
        synced <= frame_start || (synced && !row_err);
        x_ok   <= line_start || (x_ok && !col_err);
      end
      if (line_start) last_y <= pix_y;
      if (frame_start || row_origin) row_base <= '0;
      else if (row_wrap) row_base <= row_base + ADDR_W'(GRID_W);
      out_valid <= v1;
      in_grid   <= hit;
      cell_col  <= hit ? col : '0;
      cell_row  <= hit ? row : '0;
      cell_addr <= hit ? row_base + ADDR_W'(col) : '0;
      seq_err   <= err1;
    end
  end
endmodule

// File: tb/tb_vga_pixel_to_cell.sv
// tb_vga_pixel_to_cell: scoreboarded raster stimulus plus hand-computed spot vectors
module tb_vga_pixel_to_cell;
  logic clk = 1'b0, reset = 1'b1, pix_valid = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic out_valid, in_grid, seq_err;
  logic [5:0] cell_col, cell_row;
  logic [10:0] cell_addr;
  int n_run = 0, n_fail = 0, cyc = 0, cur_f = 0;
  bit mon_en = 1'b0, m_sync = 1'b0, m_xok = 1'b0;
  int m_lx = 0, m_ly = 0;
  typedef struct {int key; int due; bit in; int col; int row; int addr; bit err;} exp_t;
  typedef struct {int f; int x; int y; bit in; int col; int row; int addr; bit err;} vec_t;
  typedef struct packed {logic in; logic [5:0] col; logic [5:0] row; logic [10:0] addr; logic err;} got_t;
  exp_t sb[$];
  got_t got[int];
  vec_t vecs[$];

  vga_pixel_to_cell dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .out_valid(out_valid), .in_grid(in_grid), .cell_col(cell_col), .cell_row(cell_row),
    .cell_addr(cell_addr), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic int line_len(input int y);
    return (y == 8 || y == 50 || y == 335 || y == 336) ? 340 : 24;
  endfunction

  task automatic drive(input int x, input int y, input bit v);
    exp_t e;
    bit rerr, cerr;
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = v;
    if (v) begin
      rerr = x == 0 && y != 0 && y != m_ly + 1;
      cerr = x != 0 && x != m_lx + 1;
      e.err = m_sync && (rerr || cerr);
      m_sync = (x == 0 && y == 0) || (m_sync && !rerr);
      m_xok = (x == 0) || (m_xok && !cerr);
      m_lx = x;
      if (x == 0) m_ly = y;
      e.in = m_sync && m_xok && x >= 8 && x < 336 && y >= 8 && y < 336;
      e.col = e.in ? (x - 8) / 8 : 0;
      e.row = e.in ? (y - 8) / 8 : 0;
      e.addr = e.row * 41 + e.col;
      e.key = cur_f * (1 << 20) + y * 1024 + x;
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    n_run++;
    if ({out_valid, in_grid, seq_err, cell_col, cell_row, cell_addr} !== 26'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%b in=%b err=%b col=%0d row=%0d addr=%0d, required all 0",
               nm, out_valid, in_grid, seq_err, cell_col, cell_row, cell_addr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    pix_valid = 1'b0;
    sb.delete();
    m_sync = 1'b0; m_xok = 1'b0; m_lx = 0; m_ly = 0;
    @(negedge clk);
    #1;
    check_zero("reset_mid");
    reset = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_run++;
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          got[e.key] = {in_grid, cell_col, cell_row, cell_addr, seq_err};
          if (e.due != cyc || out_valid !== 1'b1 || in_grid !== e.in || cell_col !== 6'(e.col) ||
              cell_row !== 6'(e.row) || cell_addr !== 11'(e.addr) || seq_err !== e.err) begin
            n_fail++;
            $display("FAIL sb f%0d (%0d,%0d) due=%0d cyc=%0d: got v=%b in=%b col=%0d row=%0d addr=%0d err=%b, exp v=1 in=%b col=%0d row=%0d addr=%0d err=%b",
                     e.key >> 20, e.key % 1024, (e.key >> 10) % 1024, e.due, cyc, out_valid, in_grid,
                     cell_col, cell_row, cell_addr, seq_err, e.in, e.col, e.row, e.addr, e.err);
          end
        end else if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_valid cyc=%0d: got out_valid=%b, exp 0", cyc, out_valid);
        end
      end
    end
  endtask

  initial begin
    vecs.push_back('{0, 10, 10, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 8, 8, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 15, 8, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 16, 8, 1, 1, 0, 1, 0});
    vecs.push_back('{1, 7, 8, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 8, 7, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 335, 335, 1, 40, 40, 1680, 0});
    vecs.push_back('{1, 336, 8, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 8, 336, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 100, 50, 1, 11, 5, 216, 0});
    vecs.push_back('{2, 10, 8, 1, 0, 0, 0, 0});
    vecs.push_back('{2, 17, 8, 1, 1, 0, 1, 0});
    vecs.push_back('{2, 20, 20, 1, 1, 1, 42, 0});
    vecs.push_back('{2, 40, 20, 0, 0, 0, 0, 1});
    vecs.push_back('{2, 41, 20, 0, 0, 0, 0, 0});
    vecs.push_back('{2, 8, 21, 1, 0, 1, 41, 0});
    vecs.push_back('{2, 0, 32, 0, 0, 0, 0, 1});
    vecs.push_back('{2, 8, 32, 0, 0, 0, 0, 0});
    vecs.push_back('{2, 8, 40, 0, 0, 0, 0, 0});
    vecs.push_back('{3, 8, 200, 1, 0, 24, 984, 0});
    vecs.push_back('{4, 205, 200, 0, 0, 0, 0, 0});
    vecs.push_back('{5, 8, 8, 1, 0, 0, 0, 0});
    vecs.push_back('{5, 100, 50, 1, 11, 5, 216, 0});
    vecs.push_back('{5, 16, 16, 1, 1, 1, 42, 0});
    fork
      monitor();
      begin forever @(posedge clk) cyc++; end
    join_none
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_init");
    reset = 1'b0;
    mon_en = 1'b1;
    cur_f = 0;
    drive(5, 5, 1); drive(6, 5, 1); drive(50, 60, 1); drive(10, 10, 1);
    cur_f = 1;
    for (int y = 0; y <= 340; y++)
      for (int x = 0; x < line_len(y); x++) drive(x, y, 1);
    cur_f = 2;
    for (int y = 0; y <= 40; y++) begin
      if (y == 31) continue;
      if (y == 8) begin
        for (int x = 0; x < 24; x++) begin drive(x, y, 1); drive(x, y, 0); end
      end else if (y == 20) begin
        for (int x = 0; x <= 20; x++) drive(x, y, 1);
        for (int x = 40; x <= 60; x++) drive(x, y, 1);
      end else begin
        for (int x = 0; x < 24; x++) drive(x, y, 1);
      end
    end
    cur_f = 3;
    for (int y = 0; y < 200; y++)
      for (int x = 0; x < 24; x++) drive(x, y, 1);
    for (int x = 0; x <= 200; x++) drive(x, 200, 1);
    do_reset();
    cur_f = 4;
    for (int x = 201; x <= 210; x++) drive(x, 200, 1);
    cur_f = 5;
    for (int y = 0; y <= 60; y++)
      for (int x = 0; x < line_len(y); x++) drive(x, y, 1);
    idle();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, exp 0", sb.size());
    end
    foreach (vecs[i]) begin
      vec_t v;
      int k;
      v = vecs[i];
      k = v.f * (1 << 20) + v.y * 1024 + v.x;
      n_run++;
      if (!got.exists(k)) begin
        n_fail++;
        $display("FAIL vec f%0d (%0d,%0d): got no result, exp one", v.f, v.x, v.y);
      end else if (got[k] !== {v.in, 6'(v.col), 6'(v.row), 11'(v.addr), v.err}) begin
        n_fail++;
        $display("FAIL vec f%0d (%0d,%0d): got in=%b col=%0d row=%0d addr=%0d err=%b, exp in=%b col=%0d row=%0d addr=%0d err=%b",
                 v.f, v.x, v.y, got[k].in, got[k].col, got[k].row, got[k].addr, got[k].err,
                 v.in, v.col, v.row, v.addr, v.err);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
